track_scroller: RTL and testbench
=================================

TRACK_SCROLLER -- requirements
Module: track_scroller

Interface
REQ-001 The block SHALL use these parameters:
- SCROLL_DIV, default 1000000: clk cycles per scroll step.
- HIT_LO, default 420: lowest row index of the hit window.
- HIT_HI, default 459: highest row index of the hit window.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- run  in  1  1 = play, 0 = pause.
- key0..key3  in  1 each  lane buttons, already synchronised, 1 = pressed.
- chart_addr  out  12  chart ROM address.
- chart_data  in  5  ROM word, valid 1 cycle after chart_addr; bit4 = end marker, bits3:0 = lane notes.
- track0..track3  out  480 each  lane bitmaps; bit y = note at screen row y, row 0 at top.
- score  out  16  hit count.
- combo  out  10  consecutive hits.
- hit_pulse  out  1  one-cycle strobe per judged hit.
- miss_pulse  out  1  one-cycle strobe per miss cycle.
- done  out  1  chart finished.

Function
REQ-003 The FSM SHALL have states IDLE, RUN, FETCH, WAIT, SHIFT and DONE.
REQ-004 IDLE SHALL go to RUN when run=1.
REQ-005 The tick counter SHALL advance only in RUN with run=1; when it reaches SCROLL_DIV-1 it SHALL clear and the FSM SHALL go to FETCH.
REQ-006 FETCH SHALL drive chart_addr; WAIT SHALL absorb the 1-cycle ROM latency; SHIFT SHALL sample chart_data and return to RUN, so each step is exactly 3 cycles after the tick.
REQ-007 In SHIFT, each trackN SHALL become {trackN[478:0], lane bit N}, and chart_addr SHALL increment.
REQ-008 When the end marker has been seen, SHIFT SHALL insert zeros in all lanes and hold chart_addr.
REQ-009 chart_addr SHALL wrap from 4095 to 0 when no end marker is present.
REQ-010 A miss SHALL occur in SHIFT when any trackN[479]=1 before the shift: miss_pulse=1 for one cycle (once, even if several lanes miss) and combo=0.
REQ-011 A rising edge of keyN (registered previous value) SHALL set pending[N]; pending flags SHALL be captured in every state.
REQ-012 In RUN only, each pending[N] SHALL be judged and cleared. If trackN has a 1 in [HIT_LO..HIT_HI], the highest such index SHALL be cleared, score and combo SHALL increment, and hit_pulse=1. Otherwise there SHALL be no effect and no penalty.
REQ-013 When several lanes hit in the same cycle, score and combo SHALL increase by the number of hits, and hit_pulse SHALL be a single one-cycle pulse.
REQ-014 score SHALL saturate at 65535 and combo SHALL saturate at 1023.
REQ-015 With run=0, the counter and tracks SHALL freeze, no judgement SHALL occur, and pending flags SHALL be cleared.
REQ-016 After the end marker has been seen, once all four tracks are zero at the end of SHIFT the FSM SHALL go to DONE with done=1. DONE SHALL hold until reset.

Reset
REQ-017 With rst=0 at a clk edge, the block SHALL set: state IDLE, tick counter 0, chart_addr 0, track0..3 all zero, score 0, combo 0, pending 0, hit_pulse 0, miss_pulse 0, done 0, end-seen flag 0.
REQ-018 Reset SHALL take priority over all events, including mid-step reset in FETCH, WAIT or SHIFT; no partial shift SHALL survive.

Configuration
REQ-019 When macro TRACK_SCROLLER_AUTOPLAY_EN is defined:
- In SHIFT, any lane with bit HIT_HI set (before the shift) SHALL be auto-hit: the bit is cleared before shifting, and it is scored as in REQ-012/013.
- Key inputs SHALL be ignored.
- miss_pulse SHALL never assert.
REQ-020 When TRACK_SCROLLER_AUTOPLAY_EN is undefined, REQ-011..013 SHALL be the only hit path.

Verification
REQ-021 The bench SHALL use SCROLL_DIV=4 and cover these scenarios:
- Reset, run=1, ROM word 5'b00001 at address 0, zeros elsewhere -> after first SHIFT, track0[0]=1 and chart_addr=1; first SHIFT occurs 4+3 cycles after run asserts.
- Same note, no key press -> after 480 steps, track0[479]=1; on the next SHIFT, miss_pulse=1 for one cycle, combo=0, score=0.
- Note at track1 row 430, key1 rising edge in RUN -> track1[430]=0, score=1, combo=1, hit_pulse for one cycle; a second press with an empty window -> no change.
- key0 and key2 rising edges in the same cycle, both windows occupied -> score +2, combo +2, single hit_pulse.
- End marker at address 3 -> chart_addr holds at 3, zeros are fed, and done=1 after the last note exits; rst=0 then clears every output.
- With TRACK_SCROLLER_AUTOPLAY_EN defined, a note reaching row 459 -> cleared, score=1, and no miss ever occurs.

Source files
------------

// File: rtl/track_scroller.sv
// track_scroller: four-lane scrolling note field for a rhythm game.
// Every SCROLL_DIV clock cycles one chart word is fetched from an external
// ROM (1-cycle read latency) and shifted into the top of each lane bitmap.
// Notes travel from row 0 down to row 479. Key presses are judged against
// the hit window [HIT_LO..HIT_HI]. A note that falls off row 479 is a miss.
// Optional feature: define TRACK_SCROLLER_AUTOPLAY_EN to auto-hit every note
// as it leaves row HIT_HI. In that build the keys are ignored and no miss
// can occur.
//
// Step timing: RUN counts SCROLL_DIV cycles, then FETCH -> WAIT -> SHIFT.
// The shift lands on the third edge after the tick, and the FSM then
// returns to RUN. With run=0 every state except IDLE/DONE holds in place.
module track_scroller #(
    parameter int SCROLL_DIV = 1000000,
    parameter int HIT_LO     = 420,
    parameter int HIT_HI     = 459
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         key0,
    input  logic         key1,
    input  logic         key2,
    input  logic         key3,
    output logic [11:0]  chart_addr,
    input  logic [4:0]   chart_data,
    output logic [479:0] track0,
    output logic [479:0] track1,
    output logic [479:0] track2,
    output logic [479:0] track3,
    output logic [15:0]  score,
    output logic [9:0]   combo,
    output logic         hit_pulse,
    output logic         miss_pulse,
    output logic         done
);

`ifdef TRACK_SCROLLER_AUTOPLAY_EN
    localparam bit AUTOPLAY = 1'b1;
`else
    localparam bit AUTOPLAY = 1'b0;
`endif

    localparam int TW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SCROLL_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FETCH,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t         state;
    logic [TW-1:0]  tick;
    logic [479:0]   lane [4];
    logic [3:0]     key_q;
    logic [3:0]     pending;
    logic           end_seen;

    logic [3:0]     keys;
    logic [3:0]     rise;
    logic [3:0]     win_hit;
    logic [3:0]     auto_hit;
    logic [3:0]     lane_top;
    logic [479:0]   judged [4];
    logic [479:0]   pre_lane [4];
    logic [479:0]   shifted [4];
    logic           seen;
    logic           all_zero;
    logic           miss_any;

    assign track0 = lane[0];
    assign track1 = lane[1];
    assign track2 = lane[2];
    assign track3 = lane[3];

    assign keys = {key3, key2, key1, key0};
    // Keys only matter when autoplay is off; key_q tracks them regardless.
    assign rise = keys & ~key_q & {4{!AUTOPLAY}};

    // Clear the lowest-on-screen (highest index) note inside the hit window.
    function automatic logic [479:0] clear_highest(input logic [479:0] t);
        logic [479:0] r;
        logic         found;
        r     = t;
        found = 1'b0;
        for (int i = HIT_HI; i >= HIT_LO; i--) begin
            if (!found && t[i]) begin
                r[i]  = 1'b0;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [2:0] count4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [15:0] sat_score(input logic [15:0] a, input logic [2:0] n);
        logic [16:0] s;
        s = {1'b0, a} + {14'd0, n};
        return (s > 17'd65535) ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [9:0] sat_combo(input logic [9:0] a, input logic [2:0] n);
        logic [10:0] s;
        s = {1'b0, a} + {8'd0, n};
        return (s > 11'd1023) ? 10'd1023 : s[9:0];
    endfunction

    // Per-lane judgement (RUN) and next-row shift (SHIFT) candidates.
    always_comb begin
        win_hit  = '0;
        auto_hit = '0;
        lane_top = '0;
        seen     = end_seen | chart_data[4];
        for (int n = 0; n < 4; n++) begin
            judged[n]   = lane[n];
            pre_lane[n] = lane[n];
            win_hit[n]  = pending[n] && (|lane[n][HIT_HI:HIT_LO]);
            if (win_hit[n]) begin
                judged[n] = clear_highest(lane[n]);
            end
            auto_hit[n] = AUTOPLAY && lane[n][HIT_HI];
            if (auto_hit[n]) begin
                pre_lane[n][HIT_HI] = 1'b0;
            end
            lane_top[n] = lane[n][479];
            shifted[n]  = {pre_lane[n][478:0], seen ? 1'b0 : chart_data[n]};
        end
        all_zero = ~|(shifted[0] | shifted[1] | shifted[2] | shifted[3]);
        miss_any = !AUTOPLAY && (|lane_top);
    end

    // Main FSM: tick counting, judgement, step sequencing, scoring.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            tick       <= '0;
            chart_addr <= 12'd0;
            for (int n = 0; n < 4; n++) begin
                lane[n] <= '0;
            end
            score      <= 16'd0;
            combo      <= 10'd0;
            key_q      <= 4'd0;
            pending    <= 4'd0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            done       <= 1'b0;
            end_seen   <= 1'b0;
        end else begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            key_q      <= keys;

            // Pending flags: dropped on pause, consumed in RUN, else accumulate.
            if (!run) begin
                pending <= 4'd0;
            end else if (state == S_RUN) begin
                pending <= rise;
            end else begin
                pending <= pending | rise;
            end

            case (state)
                S_IDLE: begin
                    if (run) state <= S_RUN;
                end
                S_RUN: begin
                    if (run) begin
                        for (int n = 0; n < 4; n++) begin
                            lane[n] <= judged[n];
                        end
                        if (|win_hit) begin
                            score     <= sat_score(score, count4(win_hit));
                            combo     <= sat_combo(combo, count4(win_hit));
                            hit_pulse <= 1'b1;
                        end
                        if (tick == TICK_LAST) begin
                            tick  <= '0;
                            state <= S_FETCH;
                        end else begin
                            tick <= tick + 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    if (run) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (run) state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (run) begin
                        for (int n = 0; n < 4; n++) begin
                            lane[n] <= shifted[n];
                        end
                        end_seen <= seen;
                        if (!seen) chart_addr <= chart_addr + 12'd1;
                        if (miss_any) begin
                            miss_pulse <= 1'b1;
                            combo      <= 10'd0;
                        end else if (|auto_hit) begin
                            score     <= sat_score(score, count4(auto_hit));
                            combo     <= sat_combo(combo, count4(auto_hit));
                            hit_pulse <= 1'b1;
                        end
                        if (seen && all_zero) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_track_scroller.sv
// Directed bench for track_scroller with SCROLL_DIV=4.
// With run=1 from reset release, scroll step k lands on edge 7*k+1.
`timescale 1ns/1ps
module tb_track_scroller;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         run = 1'b0;
    logic         key0 = 1'b0;
    logic         key1 = 1'b0;
    logic         key2 = 1'b0;
    logic         key3 = 1'b0;
    logic [11:0]  chart_addr;
    logic [4:0]   chart_data = 5'd0;
    logic [479:0] track0, track1, track2, track3;
    logic [15:0]  score;
    logic [9:0]   combo;
    logic         hit_pulse, miss_pulse, done;

    logic [4:0]   rom [4096];
    int           n_checks = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           hit_cnt = 0;
    int           miss_cnt = 0;

    track_scroller #(.SCROLL_DIV(4)) dut (
        .clk(clk), .rst(rst), .run(run),
        .key0(key0), .key1(key1), .key2(key2), .key3(key3),
        .chart_addr(chart_addr), .chart_data(chart_data),
        .track0(track0), .track1(track1), .track2(track2), .track3(track3),
        .score(score), .combo(combo),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .done(done)
    );

    always #5 clk = ~clk;

    // Chart ROM model with one cycle of read latency.
    always @(posedge clk) chart_data <= rom[chart_addr];

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [479:0] obs, input logic [479:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [479:0] row(input int r);
        logic [479:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (hit_pulse) hit_cnt++;
            if (miss_pulse) miss_cnt++;
        end
    endtask

    task automatic goto_step(input int k);
        run_cycles(7 * k + 1 - cyc);
    endtask

    task automatic clear_rom;
        for (int a = 0; a < 4096; a++) rom[a] = 5'd0;
    endtask

    task automatic apply_reset;
        rst = 1'b0; run = 1'b0;
        key0 = 1'b0; key1 = 1'b0; key2 = 1'b0; key3 = 1'b0;
        run_cycles(2);
    endtask

    task automatic release_run;
        rst = 1'b1; run = 1'b1;
        cyc = 0; hit_cnt = 0; miss_cnt = 0;
    endtask

    task automatic chk_cleared(input string pfx);
        chk({pfx, "_addr"}, chart_addr, 12'd0);
        chk({pfx, "_score"}, score, 16'd0);
        chk({pfx, "_combo"}, combo, 10'd0);
        chk({pfx, "_done"}, done, 1'b0);
        chk({pfx, "_hit"}, hit_pulse, 1'b0);
        chk({pfx, "_miss"}, miss_pulse, 1'b0);
        chk({pfx, "_trk0"}, track0, '0);
        chk({pfx, "_trk1"}, track1, '0);
        chk({pfx, "_trk2"}, track2, '0);
        chk({pfx, "_trk3"}, track3, '0);
    endtask

    initial begin
`ifndef TRACK_SCROLLER_AUTOPLAY_EN
        // A: first step latency, unhit note misses, address wrap.
        clear_rom;
        rom[0] = 5'b00001;
        apply_reset;
        chk_cleared("reset");
        release_run;
        run_cycles(7);
        chk("pre_first_shift_trk0", track0, '0);
        run_cycles(1);
        chk("first_shift_trk0", track0, row(0));
        chk("first_shift_addr", chart_addr, 12'd1);
        goto_step(480);
        chk("bottom_row_trk0", track0, row(479));
        chk("no_early_miss", miss_cnt, 0);
        goto_step(481);
        chk("miss_pulse", miss_pulse, 1'b1);
        chk("miss_combo", combo, 10'd0);
        chk("miss_score", score, 16'd0);
        chk("miss_trk0_empty", track0, '0);
        chk("miss_addr", chart_addr, 12'd481);
        run_cycles(1);
        chk("miss_pulse_one_cycle", miss_pulse, 1'b0);
        goto_step(4095);
        chk("addr_4095", chart_addr, 12'd4095);
        goto_step(4096);
        chk("addr_wrap", chart_addr, 12'd0);
        chk("single_miss_total", miss_cnt, 1);

        // B: single-lane hit, then a press with an empty window.
        clear_rom;
        rom[0] = 5'b00010;
        apply_reset;
        release_run;
        goto_step(431);
        chk("b_trk1_at_430", track1, row(430));
        key1 = 1'b1;
        run_cycles(2);
        chk("b_hit_trk1", track1, '0);
        chk("b_hit_score", score, 16'd1);
        chk("b_hit_combo", combo, 10'd1);
        chk("b_hit_pulse", hit_pulse, 1'b1);
        run_cycles(1);
        chk("b_hit_pulse_end", hit_pulse, 1'b0);
        key1 = 1'b0;
        run_cycles(1);
        key1 = 1'b1;
        hit_cnt = 0;
        run_cycles(10);
        chk("b_empty_press_pulses", hit_cnt, 0);
        chk("b_empty_press_score", score, 16'd1);
        chk("b_empty_press_combo", combo, 10'd1);
        key1 = 1'b0;

        // C: two lanes hit together, highest index cleared, pause behaviour.
        clear_rom;
        rom[0] = 5'b00101;
        rom[5] = 5'b00001;
        apply_reset;
        release_run;
        goto_step(431);
        chk("c_trk0_pre", track0, row(430) | row(425));
        chk("c_trk2_pre", track2, row(430));
        key0 = 1'b1; key2 = 1'b1;
        hit_cnt = 0;
        run_cycles(2);
        chk("c_score_plus2", score, 16'd2);
        chk("c_combo_plus2", combo, 10'd2);
        chk("c_hit_pulse", hit_pulse, 1'b1);
        chk("c_trk0_highest_cleared", track0, row(425));
        chk("c_trk2_cleared", track2, '0);
        run_cycles(1);
        chk("c_hit_pulse_end", hit_pulse, 1'b0);
        chk("c_single_pulse", hit_cnt, 1);
        run = 1'b0; key0 = 1'b0; key2 = 1'b0;
        run_cycles(3);
        key0 = 1'b1;
        run_cycles(10);
        chk("c_pause_freeze_trk0", track0, row(425));
        chk("c_pause_no_judge", score, 16'd2);
        run = 1'b1;
        run_cycles(2);
        chk("c_resume_trk0", track0, row(425));
        chk("c_resume_score", score, 16'd2);
        chk("c_resume_combo", combo, 10'd2);
        key0 = 1'b0;

        // D: end marker at address 3, drain to done, then reset.
        clear_rom;
        rom[0] = 5'b00001;
        rom[2] = 5'b00100;
        rom[3] = 5'b10000;
        rom[4] = 5'b00010;
        apply_reset;
        release_run;
        goto_step(4);
        chk("d_addr_hold_3", chart_addr, 12'd3);
        chk("d_trk0_step4", track0, row(3));
        chk("d_trk2_step4", track2, row(1));
        goto_step(10);
        chk("d_addr_still_3", chart_addr, 12'd3);
        chk("d_zero_fed_trk1", track1, '0);
        chk("d_trk0_step10", track0, row(9));
        goto_step(433);
        chk("d_trk2_at_430", track2, row(430));
        key2 = 1'b1;
        run_cycles(2);
        chk("d_hit_score", score, 16'd1);
        chk("d_hit_trk2", track2, '0);
        key2 = 1'b0;
        goto_step(480);
        chk("d_not_done_yet", done, 1'b0);
        chk("d_trk0_bottom", track0, row(479));
        goto_step(481);
        chk("d_done", done, 1'b1);
        chk("d_last_miss", miss_pulse, 1'b1);
        chk("d_combo_cleared", combo, 10'd0);
        chk("d_score_kept", score, 16'd1);
        chk("d_trk0_empty", track0, '0);
        run_cycles(30);
        chk("d_done_hold", done, 1'b1);
        chk("d_addr_hold_done", chart_addr, 12'd3);
        rst = 1'b0;
        run_cycles(1);
        chk_cleared("d_reset");
        rst = 1'b1; run = 1'b0;
        run_cycles(2);
`else
        // Autoplay: keys ignored, notes auto-hit at HIT_HI, never a miss.
        clear_rom;
        rom[0] = 5'b00001;
        apply_reset;
        chk_cleared("reset");
        release_run;
        run_cycles(8);
        chk("ap_first_shift_trk0", track0, row(0));
        chk("ap_first_shift_addr", chart_addr, 12'd1);
        goto_step(431);
        key0 = 1'b1;
        run_cycles(3);
        chk("ap_key_ignored_trk0", track0, row(430));
        chk("ap_key_ignored_score", score, 16'd0);
        key0 = 1'b0;
        goto_step(460);
        chk("ap_trk0_at_459", track0, row(459));
        chk("ap_no_hit_yet", hit_cnt, 0);
        goto_step(461);
        chk("ap_auto_cleared", track0, '0);
        chk("ap_score", score, 16'd1);
        chk("ap_combo", combo, 10'd1);
        chk("ap_hit_pulse", hit_pulse, 1'b1);
        goto_step(500);
        chk("ap_never_miss", miss_cnt, 0);
        chk("ap_score_final", score, 16'd1);
        chk("ap_single_hit", hit_cnt, 1);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
